hqm_aw_elastic_buffer: RTL
==========================

HQM_AW_ELASTIC_BUFFER -- requirements
Module: hqm_AW_elastic_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload width in bits (legal 1..1024).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entry count (legal 0..31); DEPTH=0 is combinational pass-through.
REQ-003 The block SHALL have parameter NOT_EMPTY_AT_EOT, default 0, meaning end-of-test emptiness check disabled (1) or enabled (0).
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-006 The block SHALL have port flush, input, 1, synchronous discard of all stored entries.
REQ-007 The block SHALL have port status, output, 7, occupancy/full/not-empty status word.
REQ-008 The block SHALL have port in_ready, output, 1, buffer can accept this cycle.
REQ-009 The block SHALL have port in_valid, input, 1, input payload valid.
REQ-010 The block SHALL have port in_data, input, WIDTH, input payload.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts this cycle.
REQ-012 The block SHALL have port out_valid, output, 1, output payload valid.
REQ-013 The block SHALL have port out_data, output, WIDTH, output payload.

Function
REQ-014 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-015 For DEPTH>=1, in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from out_ready or in_valid.
REQ-016 For DEPTH>=1, out_valid SHALL equal (count != 0) and out_data SHALL equal the oldest entry, driven from storage with no combinational path from in_data.
REQ-017 Latency SHALL be one cycle: a push in cycle N into an empty buffer yields out_valid=1 in cycle N+1.
REQ-018 Throughput SHALL be one transfer per cycle whenever 0 < count < DEPTH, and when DEPTH=1 SHALL be one transfer per two cycles.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-020 Write/read pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-2 DEPTH.
REQ-021 Count width SHALL be $clog2(DEPTH+1), and count SHALL never exceed DEPTH or go below 0.
REQ-022 On flush=1, count and pointers SHALL be 0 next cycle; flush SHALL take priority over a same-cycle push/pop, and that cycle's push SHALL be discarded.
REQ-023 For DEPTH>=1, status SHALL be {count zero-extended to 5 bits, full, out_valid}.
REQ-024 For DEPTH=0, in_ready SHALL equal out_ready, out_valid SHALL equal in_valid, out_data SHALL equal in_data, status SHALL be {4'b0, out_ready, 1'b0, in_valid}, and flush SHALL be ignored.
REQ-025 Storage contents SHALL not require reset; only count, pointers and status SHALL be reset.
REQ-026 When NOT_EMPTY_AT_EOT=0, a simulation-only end-of-test check SHALL flag error if count != 0; it SHALL be excluded from synthesis.
REQ-027 Simulation-only assertions SHALL flag in_data change or in_valid drop while in_valid & !in_ready (input stability violation).

Reset
REQ-028 While rst=1 at a clk edge, count and pointers SHALL be cleared; rst SHALL override flush, push and pop.
REQ-029 After reset, outputs SHALL be: out_valid=0, in_ready=1 (DEPTH>=1), status=7'h00; out_data value SHALL be don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries with no partial pop.

Structure
REQ-031 Status bit-position localparams (occupancy [6:2], full [1], not-empty [0]) SHALL reside in hqm_AW_pkg and be shared with the single, double and zero buffer variants.
REQ-032 No sub-module SHALL be used; storage SHALL be a flop array selected by generate on DEPTH (0 pass-through, >=1 circular buffer).

Verification
REQ-033 The bench SHALL cover fill-and-drain: DEPTH=4, push 0xA,0xB,0xC,0xD with out_ready=0 -> in_ready=0 and status=7'b0010011 after the 4th push; out_ready=1 then drains A,B,C,D on 4 consecutive cycles.
REQ-034 The bench SHALL cover streaming: DEPTH=2, continuous push/pop of 100 beats -> one beat per cycle after a 1-cycle fill, in order, count steady at 1.
REQ-035 The bench SHALL cover wrap: DEPTH=3, 10 random push/pop beats -> data order preserved across pointer wrap, count never >3.
REQ-036 The bench SHALL cover flush: DEPTH=4 holding 3 entries, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, and the pushed beat is lost.
REQ-037 The bench SHALL cover reset mid-stream: rst=1 while count=2 -> next cycle status=7'h00, in_ready=1, out_valid=0.
REQ-038 The bench SHALL cover pass-through: DEPTH=0, in_valid=1, out_ready=0, in_data=0x55 -> same-cycle out_valid=1, out_data=0x55, in_ready=0, status=7'b0000001.

Source files
------------

// File: rtl/hqm_AW_pkg.sv
// Shared definitions for the hqm_AW buffer family (zero, single, double and
// elastic variants). Every variant uses the same status word layout.
package hqm_AW_pkg;

  // Status word layout: {occupancy[6:2], full[1], not_empty[0]}
  localparam int HQM_AW_STATUS_W       = 7;
  localparam int HQM_AW_STATUS_OCC_MSB = 6;
  localparam int HQM_AW_STATUS_OCC_LSB = 2;
  localparam int HQM_AW_STATUS_FULL    = 1;
  localparam int HQM_AW_STATUS_NEMPTY  = 0;
  localparam int HQM_AW_OCC_W          = HQM_AW_STATUS_OCC_MSB - HQM_AW_STATUS_OCC_LSB + 1;

  // Assemble a status word from its fields so all variants agree on bit positions.
  function automatic logic [HQM_AW_STATUS_W-1:0] hqm_aw_pack_status(
    input logic [HQM_AW_OCC_W-1:0] occ,
    input logic                    full,
    input logic                    not_empty
  );
    logic [HQM_AW_STATUS_W-1:0] s;
    s = '0;
    s[HQM_AW_STATUS_OCC_MSB:HQM_AW_STATUS_OCC_LSB] = occ;
    s[HQM_AW_STATUS_FULL]                          = full;
    s[HQM_AW_STATUS_NEMPTY]                        = not_empty;
    return s;
  endfunction

endpackage

// File: rtl/hqm_aw_elastic_buffer.sv
// Valid/ready elastic buffer. DEPTH=0 is a wire-through; DEPTH>=1 is a
// circular flop-array FIFO whose handshake outputs come only from registered
// state, so it breaks the combinational ready and data paths.
module hqm_aw_elastic_buffer
  import hqm_AW_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int DEPTH            = 2,
  parameter int NOT_EMPTY_AT_EOT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  output logic [HQM_AW_STATUS_W-1:0] status,
  output logic                       in_ready,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data
);

  if (DEPTH == 0) begin : g_pass

    // No storage: the producer talks straight to the consumer.
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign status    = hqm_aw_pack_status(HQM_AW_OCC_W'(out_ready), 1'b0, in_valid);

    // clk, rst and flush have nothing to act on in this configuration.
    logic w_unused_pass;
    assign w_unused_pass = &{1'b0, clk, rst, flush};

  end else begin : g_buf

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_not_empty;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wptr_inc;
    logic [PTR_W-1:0] w_rptr_inc;

    assign w_full      = (r_count == CNT_MAX);
    assign w_not_empty = (r_count != '0);
    assign w_push      = in_valid & ~w_full;
    assign w_pop       = w_not_empty & out_ready;

    // Explicit wrap compare so non-power-of-2 depths cycle through DEPTH slots.
    assign w_wptr_inc = (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
    assign w_rptr_inc = (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);

    // Occupancy and pointers; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= w_wptr_inc;
        end
        if (w_pop) begin
          r_rptr <= w_rptr_inc;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Payload storage carries no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
      if (!rst && !flush && w_push) begin
        r_mem[r_wptr] <= in_data;
      end
    end

    assign in_ready  = ~w_full;
    assign out_valid = w_not_empty;
    assign out_data  = r_mem[r_rptr];
    assign status    = hqm_aw_pack_status(HQM_AW_OCC_W'(r_count), w_full, w_not_empty);

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (rst) (r_count <= CNT_MAX))
      else $error("hqm_aw_elastic_buffer: occupancy %0d exceeds depth %0d", r_count, DEPTH);

    // Leftover entries at end of simulation usually mean lost traffic.
    final begin
      if (NOT_EMPTY_AT_EOT == 0 && r_count != '0) begin
        $error("hqm_aw_elastic_buffer: %0d entries still held at end of test", r_count);
      end
    end
`endif

  end

`ifndef SYNTHESIS
  // A producer stalled by !in_ready must hold its beat unchanged; a flush
  // cycle releases it because the beat is discarded anyway.
  a_in_stable: assert property (@(posedge clk) disable iff (rst)
                                (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)))
    else $error("hqm_aw_elastic_buffer: input changed while stalled");
`endif

endmodule
